// File: rtl/player_link_tx.sv
// player_link_tx: transmit side of the inter-board player link.
// A 3-bit move taken through a valid/ready handshake goes out as one strobe
// frame: the data lines are driven first, then the strobe is raised and
// lowered, then the data is held for a while before the lines return to 000.
// Every output comes straight from a flop, so the strobe cannot glitch and the
// data lines never move on a cycle where the strobe changes.
module player_link_tx #(
  parameter int SETUP_CYCLES = 4,  // cycles of data with strobe low before the rising edge
  parameter int HIGH_CYCLES  = 8,  // cycles the strobe stays high
  parameter int HOLD_CYCLES  = 4,  // cycles of data held after the falling edge
  parameter int CNT_W        = 8   // width of the completed-frame counter
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             move_valid,
  input  logic [2:0]       move,
  output logic             move_ready,
  output logic [2:0]       link_data,
  output logic             link_clk,
  output logic             busy,
  output logic [CNT_W-1:0] frame_count
);

  // The phase counter only has to reach the longest phase length minus one.
  localparam int MAX_CYC = (SETUP_CYCLES > HIGH_CYCLES) ?
                           ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES) :
                           ((HIGH_CYCLES  > HOLD_CYCLES) ? HIGH_CYCLES  : HOLD_CYCLES);
  localparam int CW = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] HIGH_LAST  = CW'(HIGH_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    HIGH  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       link_data_q, link_data_d;
  logic             link_clk_q, link_clk_d;
  logic             move_ready_q, move_ready_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] frame_count_q, frame_count_d;
  logic             accept;

  // A move is taken only when the registered ready is already showing, so the
  // first cycle after reset release never accepts.
  assign accept = move_valid & move_ready_q;

  // Next-state and next-output decode; every output is computed one cycle
  // ahead so it can be registered.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q + 1'b1;
    link_data_d   = link_data_q;
    link_clk_d    = link_clk_q;
    frame_count_d = frame_count_q;

    case (state_q)
      IDLE: begin
        cnt_d       = '0;
        link_data_d = 3'b000;
        link_clk_d  = 1'b0;
        if (accept) begin
          state_d     = SETUP;
          link_data_d = move;
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d    = HIGH;
          cnt_d      = '0;
          link_clk_d = 1'b1;
        end
      end
      HIGH: begin
        if (cnt_q == HIGH_LAST) begin
          state_d    = HOLD;
          cnt_d      = '0;
          link_clk_d = 1'b0;
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d       = IDLE;
          cnt_d         = '0;
          link_data_d   = 3'b000;
          frame_count_d = frame_count_q + 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        cnt_d       = '0;
        link_data_d = 3'b000;
        link_clk_d  = 1'b0;
      end
    endcase

    // Ready is a decode of the state about to be entered, so it lines up
    // with the registered state; busy is its complement outside reset.
    move_ready_d = (state_d == IDLE);
    busy_d       = ~move_ready_d;
  end

  // State and output registers; reset abandons any frame in flight and does
  // not count it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      link_data_q   <= 3'b000;
      link_clk_q    <= 1'b0;
      move_ready_q  <= 1'b0;
      busy_q        <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      link_data_q   <= link_data_d;
      link_clk_q    <= link_clk_d;
      move_ready_q  <= move_ready_d;
      busy_q        <= busy_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign move_ready  = move_ready_q;
  assign link_data   = link_data_q;
  assign link_clk    = link_clk_q;
  assign busy        = busy_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_player_link_tx.sv
// Directed bench for player_link_tx: a default-width instance and a 2-bit
// frame-counter instance share the same stimulus. Outputs are sampled on the
// falling clock edge; inputs change there too.
module tb_player_link_tx;

  logic       clk;
  logic       reset_n;
  logic       move_valid;
  logic [2:0] move;

  logic       move_ready, link_clk, busy;
  logic [2:0] link_data;
  logic [7:0] frame_count;

  logic       move_ready_w, link_clk_w, busy_w;
  logic [2:0] link_data_w;
  logic [1:0] frame_count_w;

  int n_checks;
  int n_pass;
  int exp_cnt;

  player_link_tx dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .move_valid  (move_valid),
    .move        (move),
    .move_ready  (move_ready),
    .link_data   (link_data),
    .link_clk    (link_clk),
    .busy        (busy),
    .frame_count (frame_count)
  );

  player_link_tx #(.CNT_W(2)) dut_w (
    .clk         (clk),
    .reset_n     (reset_n),
    .move_valid  (move_valid),
    .move        (move),
    .move_ready  (move_ready_w),
    .link_data   (link_data_w),
    .link_clk    (link_clk_w),
    .busy        (busy_w),
    .frame_count (frame_count_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Idle-cycle expectations for both instances.
  task automatic check_idle(input string tag);
    check({tag, "_clk"},   link_clk,   0);
    check({tag, "_data"},  link_data,  0);
    check({tag, "_ready"}, move_ready, 1);
    check({tag, "_busy"},  busy,       0);
    check({tag, "_cnt"},   frame_count, exp_cnt[7:0]);
    check({tag, "_wcnt"},  frame_count_w, exp_cnt[1:0]);
  endtask

  // One complete frame with acceptance on the next rising edge (edge T).
  // Observation k is taken after edge T+k-1: data for k=1..16, strobe high for
  // k=5..12, idle at k=17. hold keeps move_valid high with nxt offered;
  // pulse_k>0 offers 110 for one edge during the frame.
  task automatic frame(input logic [2:0] mv, input bit hold, input logic [2:0] nxt,
                       input int pulse_k, input string tag);
    move_valid = 1'b1;
    move       = mv;
    check($sformatf("%s_ready_pre", tag), move_ready, 1);
    @(negedge clk);
    for (int k = 1; k <= 16; k++) begin
      check($sformatf("%s_data_k%0d", tag, k), link_data, mv);
      check($sformatf("%s_clk_k%0d", tag, k), link_clk, (k >= 5 && k <= 12) ? 1 : 0);
      check($sformatf("%s_ready_k%0d", tag, k), move_ready, 0);
      check($sformatf("%s_busy_k%0d", tag, k), busy, 1);
      check($sformatf("%s_wclk_k%0d", tag, k), link_clk_w, (k >= 5 && k <= 12) ? 1 : 0);
      if (k == 1) begin
        move_valid = hold;
        move       = hold ? nxt : 3'b000;
      end
      if (pulse_k != 0 && k == pulse_k) begin
        move_valid = 1'b1;
        move       = 3'b110;
      end
      if (pulse_k != 0 && k == pulse_k + 1) move_valid = 1'b0;
      @(negedge clk);
    end
    exp_cnt = exp_cnt + 1;
    check_idle($sformatf("%s_end", tag));
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    exp_cnt    = 0;
    reset_n    = 1'b0;
    move_valid = 1'b0;
    move       = 3'b000;

    // Reset held for two cycles.
    repeat (2) @(negedge clk);
    check("rst_ready", move_ready, 0);
    check("rst_busy",  busy,       0);
    check("rst_clk",   link_clk,   0);
    check("rst_data",  link_data,  0);
    check("rst_cnt",   frame_count, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Idle for 20 cycles with nothing offered.
    for (int i = 0; i < 20; i++) begin
      check_idle($sformatf("idle%0d", i));
      @(negedge clk);
    end

    // Reset while the strobe is high: accept 010, reset lands on edge T+8.
    move_valid = 1'b1;
    move       = 3'b010;
    @(negedge clk);
    move_valid = 1'b0;
    for (int k = 1; k < 8; k++) @(negedge clk);
    check("abort_clk_high", link_clk, 1);
    check("abort_data",     link_data, 3'b010);
    reset_n = 1'b0;
    @(negedge clk);
    check("abort_rst_clk",   link_clk,    0);
    check("abort_rst_data",  link_data,   0);
    check("abort_rst_ready", move_ready,  0);
    check("abort_rst_cnt",   frame_count, exp_cnt[7:0]);
    reset_n = 1'b1;
    @(negedge clk);
    check_idle("abort_release");

    // Single frame with default timing.
    frame(3'b101, 1'b0, 3'b000, 0, "single");

    // Offer 110 while busy; only 011 goes out.
    frame(3'b011, 1'b0, 3'b000, 3, "ignore");
    @(negedge clk);
    check_idle("ignore_after");

    // 110 goes out once re-offered.
    frame(3'b110, 1'b0, 3'b000, 0, "reoffer");

    // Back-to-back with move_valid held: exactly one idle cycle between.
    frame(3'b001, 1'b1, 3'b111, 0, "b2b_a");
    frame(3'b111, 1'b0, 3'b000, 0, "b2b_b");
    @(negedge clk);
    check_idle("final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
